// File: rtl/fall_alarm_controller_pkg.sv
// Shared definitions for the fall alarm controller: FSM state encodings and
// default parameter values.
package fall_alarm_controller_pkg;

  typedef enum logic [1:0] {
    FA_IDLE     = 2'd0,
    FA_CONFIRM  = 2'd1,
    FA_ALARM    = 2'd2,
    FA_ESCALATE = 2'd3
  } fa_state_e;

  localparam int FA_DEF_CONFIRM_CNT = 4;
  localparam int FA_DEF_TIMEOUT     = 16;
  localparam int FA_DEF_CNT_W       = 8;

endpackage

// File: rtl/fall_alarm_controller_sat_counter.sv
// Saturating up-counter with increment enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fall_alarm_controller.sv
// Qualifies fallDetected over consecutive valid samples, raises a latched alarm,
// escalates if unacknowledged, and keeps a saturating count of confirmed falls.
module fall_alarm_controller #(
  parameter int CONFIRM_CNT = fall_alarm_controller_pkg::FA_DEF_CONFIRM_CNT,
  parameter int TIMEOUT     = fall_alarm_controller_pkg::FA_DEF_TIMEOUT,
  parameter int CNT_W       = fall_alarm_controller_pkg::FA_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sampleValid,
  input  logic             fallDetected,
  input  logic             alarmAck,
  output logic             alarmActive,
  output logic             escalate,
  output logic [CNT_W-1:0] fallCount,
  output logic [1:0]       ctrlState
);

  import fall_alarm_controller_pkg::*;

  localparam int CW = $clog2(CONFIRM_CNT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CONF_LAST = CW'(CONFIRM_CNT - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  fa_state_e     state_q, state_d;
  logic [CW-1:0] conf_cnt_q, conf_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          count_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FA_IDLE;
      conf_cnt_q <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      conf_cnt_q <= conf_cnt_d;
      timer_q    <= timer_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    conf_cnt_d = conf_cnt_q;
    timer_d    = timer_q;
    count_inc  = 1'b0;
    case (state_q)
      FA_IDLE: begin
        if (sampleValid && fallDetected) begin
          if (CONFIRM_CNT == 1) begin
            state_d    = FA_ALARM;
            conf_cnt_d = '0;
            timer_d    = '0;
            count_inc  = 1'b1;
          end else begin
            state_d    = FA_CONFIRM;
            conf_cnt_d = CW'(1);
          end
        end
      end
      FA_CONFIRM: begin
        // Invalid samples are gaps: they neither extend nor break the run.
        if (sampleValid) begin
          if (!fallDetected) begin
            state_d    = FA_IDLE;
            conf_cnt_d = '0;
          end else if (conf_cnt_q == CONF_LAST) begin
            state_d    = FA_ALARM;
            conf_cnt_d = '0;
            timer_d    = '0;
            count_inc  = 1'b1;
          end else begin
            conf_cnt_d = conf_cnt_q + CW'(1);
          end
        end
      end
      FA_ALARM: begin
        // An acknowledge on the timeout cycle takes priority over escalation.
        if (alarmAck) begin
          state_d = FA_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
          if (timer_q == TMO_LAST) begin
            state_d = FA_ESCALATE;
          end
        end
      end
      FA_ESCALATE: begin
        if (alarmAck) begin
          state_d = FA_IDLE;
        end
      end
      default: state_d = FA_IDLE;
    endcase
  end

  sat_counter #(
    .W(CNT_W)
  ) u_fall_count (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (count_inc),
    .count_o(fallCount)
  );

  assign alarmActive = (state_q == FA_ALARM) || (state_q == FA_ESCALATE);
  assign escalate    = (state_q == FA_ESCALATE);
  assign ctrlState   = state_q;

endmodule
